// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM single-port RAM arbiter: FSM state, owner tag and
// a counter-width helper.
package mem_arb_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM stages, the arbiter and the RAM.
// The arbiter uses the slave view; the pipeline/RAM side uses the master view.
interface mem_port_arbiter_if #(
  parameter int WIDTH      = 12,
  parameter int DATA_WIDTH = 16
);
  logic                  i_req;
  logic [WIDTH-1:0]      i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [WIDTH-1:0]      d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb_prio.sv
// Winner select for the shared RAM: D side wins ties unless I has been passed
// over STARVE_LIMIT times in a row.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic fire,
  output logic grant_i,
  output logic grant_d
);
  localparam int            SW  = cnt_w(STARVE_LIMIT);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [SW-1:0] streak;
  logic          starved;

  assign starved = (streak == LIM);

  always_comb begin
    grant_i = fire & i_req & (~d_req | starved);
    grant_d = fire & d_req & ~(i_req & starved);
  end

  // Streak only moves in arbitration cycles; it holds while a transaction is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (fire) begin
      if (grant_i || !i_req)
        streak <= '0;
      else if (grant_d && !starved)
        streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store,
// one transaction outstanding, fixed read latency MEM_LAT.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH        = 12,
  parameter int DATA_WIDTH   = 16,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int                    LW     = cnt_w(MEM_LAT);
  localparam logic [LW-1:0]         LAT    = LW'(MEM_LAT);
  localparam logic [WIDTH-1:0]      ADDR_Z = '0;
  localparam logic [DATA_WIDTH-1:0] DATA_Z = '0;

  state_e        state;
  owner_e        owner;
  logic [LW-1:0] lat_cnt;
  logic          we_q;
  logic          fire;
  logic          grant_i;
  logic          grant_d;

  // Reset must also block grants, otherwise a held request leaks through as mem_en.
  assign fire = (state == ST_IDLE) & ~reset;

  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk     (clk),
    .reset   (reset),
    .i_req   (bus.i_req),
    .d_req   (bus.d_req),
    .fire    (fire),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_comb begin
    bus.i_gnt     = grant_i;
    bus.d_gnt     = grant_d;
    bus.mem_en    = grant_i | grant_d;
    bus.mem_we    = grant_d & bus.d_we;
    bus.mem_addr  = grant_d ? bus.d_addr : (grant_i ? bus.i_addr : ADDR_Z);
    bus.mem_wdata = grant_d ? bus.d_wdata : DATA_Z;
    bus.busy      = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      owner        <= OWN_D;
      lat_cnt      <= '0;
      we_q         <= 1'b0;
      bus.i_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      bus.i_rdata  <= DATA_Z;
      bus.d_rdata  <= DATA_Z;
    end else begin
      bus.i_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_i || grant_d) begin
            state   <= ST_WAIT;
            lat_cnt <= LAT;
            owner   <= grant_d ? OWN_D : OWN_I;
            we_q    <= grant_d & bus.d_we;
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          // Last latency cycle: RAM data is on mem_rdata now, response pulses next cycle.
          if (lat_cnt == LW'(1)) begin
            state <= ST_IDLE;
            if (owner == OWN_I) begin
              bus.i_rvalid <= 1'b1;
              bus.i_rdata  <= bus.mem_rdata;
            end else begin
              bus.d_rvalid <= 1'b1;
              if (!we_q)
                bus.d_rdata <= bus.mem_rdata;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 2-cycle-read RAM model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic preload;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WIDTH(12), .DATA_WIDTH(16)) bus ();

  mem_port_arbiter #(
    .WIDTH(12), .DATA_WIDTH(16), .MEM_LAT(2), .STARVE_LIMIT(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // RAM model: write on mem_en&mem_we, read data two cycles after mem_en.
  logic [15:0] ram [0:4095];
  logic [15:0] rd1, rd2;

  always @(posedge clk) begin
    if (preload) begin
      ram[12'h010] <= 16'hBEEF;
      ram[12'h000] <= 16'h1111;
      ram[12'h001] <= 16'h2222;
      ram[12'h002] <= 16'h3333;
    end
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      rd1 <= ram[bus.mem_addr];
    end
    rd2 <= rd1;
  end

  assign bus.mem_rdata = rd2;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    logic       exp_i, exp_d;
    logic [1:0] s;
    logic [15:0] exp6;

    reset       = 1'b1;
    preload     = 1'b1;
    bus.i_req   = 1'b1;
    bus.i_addr  = 12'h010;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    // 1: reset with a pending fetch
    for (int c = 0; c < 3; c++) begin
      nxt;
      preload = 1'b0;
      smp;
      chk("rst_i_gnt", bus.i_gnt, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_busy", bus.busy, 0);
    end
    chk("rst_d_gnt", bus.d_gnt, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_i_rvalid", bus.i_rvalid, 0);
    chk("rst_d_rvalid", bus.d_rvalid, 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);

    // 2: single fetch
    nxt; reset = 1'b0; smp;
    chk("f_i_gnt", bus.i_gnt, 1);
    chk("f_mem_en", bus.mem_en, 1);
    chk("f_mem_addr", bus.mem_addr, 12'h010);
    chk("f_mem_we", bus.mem_we, 0);
    chk("f_busy_T", bus.busy, 0);
    nxt; bus.i_req = 1'b0; smp;
    chk("f_busy_T1", bus.busy, 1);
    chk("f_gnt_wait", bus.i_gnt, 0);
    chk("f_en_wait", bus.mem_en, 0);
    nxt; smp;
    chk("f_busy_T2", bus.busy, 1);
    chk("f_rvalid_T2", bus.i_rvalid, 0);
    nxt; smp;
    chk("f_rvalid_T3", bus.i_rvalid, 1);
    chk("f_rdata", bus.i_rdata, 16'hBEEF);
    chk("f_busy_T3", bus.busy, 0);

    // 3: store then load
    nxt;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'h3FF; bus.d_wdata = 16'h1234;
    smp;
    chk("st_d_gnt", bus.d_gnt, 1);
    chk("st_mem_we", bus.mem_we, 1);
    chk("st_mem_addr", bus.mem_addr, 12'h3FF);
    chk("st_mem_wdata", bus.mem_wdata, 16'h1234);
    chk("st_i_rvalid_off", bus.i_rvalid, 0);
    chk("st_i_rdata_hold", bus.i_rdata, 16'hBEEF);
    nxt; bus.d_req = 1'b0; smp;
    nxt; smp;
    nxt; bus.d_req = 1'b1; bus.d_we = 1'b0; smp;
    chk("st_d_rvalid", bus.d_rvalid, 1);
    chk("st_ram", ram[12'h3FF], 16'h1234);
    chk("st_no_capture", bus.d_rdata, 0);
    chk("ld_d_gnt", bus.d_gnt, 1);
    chk("ld_mem_we", bus.mem_we, 0);
    nxt; bus.d_req = 1'b0; smp;
    nxt; smp;
    nxt; smp;
    chk("ld_d_rvalid", bus.d_rvalid, 1);
    chk("ld_d_rdata", bus.d_rdata, 16'h1234);

    // 4: contention, expected D,D,D,D,I,D
    nxt;
    bus.i_req = 1'b1; bus.i_addr = 12'h020;
    bus.d_req = 1'b1; bus.d_addr = 12'h030; bus.d_we = 1'b0;
    for (int c = 0; c < 18; c++) begin
      smp;
      s     = 2'((c / 3) == 4);
      exp_i = (c % 3 == 0) && (s == 2'd1);
      exp_d = (c % 3 == 0) && (s == 2'd0);
      chk($sformatf("ct_gnt_c%0d", c), {bus.i_gnt, bus.d_gnt}, {exp_i, exp_d});
      if (c == 12) begin
        chk("ct_i_addr", bus.mem_addr, 12'h020);
        chk("ct_i_we", bus.mem_we, 0);
      end
      nxt;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;

    // 5a: withdrawn D request while busy
    bus.i_req = 1'b1; bus.i_addr = 12'h001;
    smp;
    chk("wd_i_gnt", bus.i_gnt, 1);
    nxt; bus.i_req = 1'b0; bus.d_req = 1'b1; bus.d_addr = 12'h005; smp;
    chk("wd_d_gnt_wait", bus.d_gnt, 0);
    nxt; bus.d_req = 1'b0; smp;
    nxt; smp;
    chk("wd_i_rvalid", bus.i_rvalid, 1);
    chk("wd_i_rdata", bus.i_rdata, 16'h2222);
    chk("wd_mem_en", bus.mem_en, 0);
    chk("wd_d_gnt", bus.d_gnt, 0);
    nxt; smp;
    chk("wd_d_rvalid", bus.d_rvalid, 0);
    chk("wd_busy", bus.busy, 0);

    // 5b: reset during WAIT drops the fetch
    nxt; bus.i_req = 1'b1; bus.i_addr = 12'h002; smp;
    chk("mr_i_gnt", bus.i_gnt, 1);
    nxt; bus.i_req = 1'b0; reset = 1'b1; smp;
    chk("mr_busy_T1", bus.busy, 1);
    nxt; reset = 1'b0; smp;
    chk("mr_busy_T2", bus.busy, 0);
    chk("mr_i_rdata", bus.i_rdata, 0);
    chk("mr_i_rvalid_T2", bus.i_rvalid, 0);
    nxt; smp;
    chk("mr_i_rvalid_T3", bus.i_rvalid, 0);

    // 6: back-to-back fetches from 0,1,2
    nxt;
    for (int c = 0; c < 10; c++) begin
      bus.i_req  = (c < 7);
      bus.i_addr = 12'(c / 3);
      smp;
      chk($sformatf("bb_gnt_c%0d", c), bus.i_gnt, (c % 3 == 0) && (c < 9));
      if ((c % 3 == 0) && (c < 9))
        chk($sformatf("bb_addr_c%0d", c), bus.mem_addr, 12'(c / 3));
      chk($sformatf("bb_rvalid_c%0d", c), bus.i_rvalid, (c > 0) && (c % 3 == 0));
      if ((c > 0) && (c % 3 == 0)) begin
        case (c / 3)
          1:       exp6 = 16'h1111;
          2:       exp6 = 16'h2222;
          default: exp6 = 16'h3333;
        endcase
        chk($sformatf("bb_rdata_c%0d", c), bus.i_rdata, exp6);
      end
      nxt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
